pc_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter. It issues one-outstanding requests to instruction memory and delivers fetched words downstream with a valid/ready handshake. It applies branch/jump redirects from the execute stage and kills in-flight fetches made stale by a redirect. It sits between the PC datapath and the decode stage.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the instruction-fetch sequencer: fetch FSM states and
// default fetch parameters.
package pc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_e;

   localparam int unsigned PC_INSN_BYTES = 4;
   localparam logic [31:0] PC_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: an aligned redirect target wins, else sequential advance,
// else hold. Also flags a misaligned redirect target.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned INSN_BYTES = PC_INSN_BYTES
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            redir_valid_i,
   input  logic [XLEN-1:0] redir_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_next_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] pc_inc;

   // Wraps modulo 2^XLEN by construction.
   assign pc_inc = pc_i + XLEN'(INSN_BYTES);

   always_comb begin
      pc_next_o  = pc_i;
      misalign_o = 1'b0;
      if (redir_valid_i) begin
         pc_next_o  = {redir_pc_i[XLEN-1:2], 2'b00};
         misalign_o = (redir_pc_i[1:0] != 2'b00);
      end else if (advance_i) begin
         pc_next_o = pc_inc;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding fetches,
// delivers words to decode and kills fetches made stale by a redirect.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(PC_RESET_PC),
   parameter int unsigned     INSN_BYTES = PC_INSN_BYTES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            insn_valid,
   output logic [XLEN-1:0] insn,
   output logic [XLEN-1:0] insn_pc,
   input  logic            insn_ready,
   output logic            exc_misalign,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     fetch_count
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] insn_q, insn_d;
   logic [XLEN-1:0] insn_pc_q, insn_pc_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            kill_q, kill_d;
   logic            exc_q;
   logic            advance;
   logic            misalign;

   pc_next_sel #(
      .XLEN       (XLEN),
      .INSN_BYTES (INSN_BYTES)
   ) u_next_sel (
      .pc_i          (pc_q),
      .redir_valid_i (redir_valid),
      .redir_pc_i    (redir_pc),
      .advance_i     (advance),
      .pc_next_o     (pc_d),
      .misalign_o    (misalign)
   );

   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      insn_d    = insn_q;
      insn_pc_d = insn_pc_q;
      cnt_d     = cnt_q;
      advance   = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // A redirect coinciding with grant still lets the old request go out.
            if (imem_gnt) begin
               state_d = WAIT;
               kill_d  = redir_valid;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (kill_q || redir_valid) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  insn_d    = imem_rdata;
                  insn_pc_d = pc_q;
                  advance   = 1'b1;
                  state_d   = HOLD;
               end
            end else if (redir_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (insn_ready) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = REQ;
            end else if (redir_valid) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         insn_q    <= '0;
         insn_pc_q <= '0;
         cnt_q     <= '0;
         kill_q    <= 1'b0;
         exc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         insn_q    <= insn_d;
         insn_pc_q <= insn_pc_d;
         cnt_q     <= cnt_d;
         kill_q    <= kill_d;
         exc_q     <= misalign;
      end
   end

   assign imem_req     = (state_q == REQ);
   assign imem_addr    = pc_q;
   assign insn_valid   = (state_q == HOLD);
   assign insn         = insn_q;
   assign insn_pc      = insn_pc_q;
   assign exc_misalign = exc_q;
   assign pc           = pc_q;
   assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        insn_valid;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        insn_ready = 1'b0;
   logic        exc_misalign;
   logic [31:0] pc;
   logic [31:0] fetch_count;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .INSN_BYTES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .redir_valid  (redir_valid),
      .redir_pc     (redir_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .insn_valid   (insn_valid),
      .insn         (insn),
      .insn_pc      (insn_pc),
      .insn_ready   (insn_ready),
      .exc_misalign (exc_misalign),
      .pc           (pc),
      .fetch_count  (fetch_count)
   );

   // Model view: started = past the post-reset idle cycle, busy = request
   // granted and awaiting data, stale = that data must be dropped,
   // have = a word is being offered to decode.
   typedef struct packed {
      logic        started;
      logic        busy;
      logic        stale;
      logic        have;
      logic        exc;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] ipc;
      logic [31:0] cnt;
   } mdl_t;

   mdl_t m = '0;

   function automatic mdl_t step(mdl_t cur, logic rst_n, logic rv_dir, logic [31:0] rpc,
                                 logic gnt, logic rv, logic [31:0] rd, logic rdy);
      mdl_t n = cur;
      logic req;
      if (!rst_n) begin
         n = '0;
         return n;
      end
      req   = cur.started && !cur.busy && !cur.have;
      n.exc = rv_dir && (rpc[1:0] != 2'b00);
      if (!cur.started) begin
         n.started = 1'b1;
      end else if (req) begin
         if (gnt) begin
            n.busy  = 1'b1;
            n.stale = rv_dir;
         end
      end else if (cur.busy) begin
         if (rv) begin
            n.busy  = 1'b0;
            n.stale = 1'b0;
            if (!(cur.stale || rv_dir)) begin
               n.have = 1'b1;
               n.insn = rd;
               n.ipc  = cur.pc;
               n.pc   = cur.pc + 32'd4;
            end
         end else if (rv_dir) begin
            n.stale = 1'b1;
         end
      end else if (cur.have) begin
         if (rdy) begin
            n.cnt  = cur.cnt + 32'd1;
            n.have = 1'b0;
         end else if (rv_dir) begin
            n.have = 1'b0;
         end
      end
      if (rv_dir) n.pc = {rpc[31:2], 2'b00};
      return n;
   endfunction

   always @(posedge clk)
      m <= step(m, rst, redir_valid, redir_pc, imem_gnt, imem_rvalid, imem_rdata, insn_ready);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_imem_req", 32'(imem_req), 32'(m.started && !m.busy && !m.have));
      chk("m_imem_addr", imem_addr, m.pc);
      chk("m_pc", pc, m.pc);
      chk("m_insn_valid", 32'(insn_valid), 32'(m.have));
      chk("m_insn", insn, m.insn);
      chk("m_insn_pc", insn_pc, m.ipc);
      chk("m_exc", 32'(exc_misalign), 32'(m.exc));
      chk("m_count", fetch_count, m.cnt);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset and first fetch
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(insn_valid), 32'd0);
      rst = 1'b1;
      tick();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      tick();
      imem_rvalid = 1'b0;
      chk("t1_valid", 32'(insn_valid), 32'd1);
      chk("t1_insn", insn, 32'h0000_0013);
      chk("t1_insn_pc", insn_pc, 32'h0);
      insn_ready = 1'b1;
      tick();
      insn_ready = 1'b0;
      chk("t1_next_addr", imem_addr, 32'h4);
      chk("t1_count", fetch_count, 32'd1);

      // Backpressure in HOLD
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_AAAA;
      tick();
      imem_rvalid = 1'b0;
      repeat (5) tick();
      chk("t2_valid", 32'(insn_valid), 32'd1);
      chk("t2_insn", insn, 32'h0000_AAAA);
      chk("t2_insn_pc", insn_pc, 32'h4);
      chk("t2_no_req", 32'(imem_req), 32'd0);
      insn_ready = 1'b1;
      tick();
      insn_ready = 1'b0;
      chk("t2_count", fetch_count, 32'd2);
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'h8);

      // Kill in flight
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; redir_valid = 1'b1; redir_pc = 32'h100;
      tick();
      redir_valid = 1'b0;
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_DEAD;
      tick();
      imem_rvalid = 1'b0;
      chk("t3_valid", 32'(insn_valid), 32'd0);
      chk("t3_insn", insn, 32'h0000_AAAA);
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'h100);

      // Redirect and grant in the same REQ cycle
      imem_gnt = 1'b1; redir_valid = 1'b1; redir_pc = 32'h200;
      tick();
      imem_gnt = 1'b0; redir_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
      tick();
      imem_rvalid = 1'b0;
      chk("t4_valid", 32'(insn_valid), 32'd0);
      chk("t4_req", 32'(imem_req), 32'd1);
      chk("t4_addr", imem_addr, 32'h200);

      // Misaligned redirect and PC wrap
      redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFE;
      tick();
      redir_valid = 1'b0;
      chk("t5_exc", 32'(exc_misalign), 32'd1);
      chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("t5_exc_clr", 32'(exc_misalign), 32'd0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
      tick();
      imem_rvalid = 1'b0;
      chk("t5_insn_pc", insn_pc, 32'hFFFF_FFFC);
      chk("t5_pc_wrap", pc, 32'h0);
      insn_ready = 1'b1;
      tick();
      insn_ready = 1'b0;
      chk("t5_addr_wrap", imem_addr, 32'h0);
      chk("t5_count", fetch_count, 32'd3);

      // Redirect in HOLD with and without insn_ready
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_5555;
      tick();
      imem_rvalid = 1'b0; redir_valid = 1'b1; redir_pc = 32'h40; insn_ready = 1'b1;
      tick();
      redir_valid = 1'b0; insn_ready = 1'b0;
      chk("t6_count", fetch_count, 32'd4);
      chk("t6_addr", imem_addr, 32'h40);
      chk("t6_valid", 32'(insn_valid), 32'd0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_6666;
      tick();
      imem_rvalid = 1'b0; redir_valid = 1'b1; redir_pc = 32'h80;
      tick();
      redir_valid = 1'b0;
      chk("t6b_count", fetch_count, 32'd4);
      chk("t6b_valid", 32'(insn_valid), 32'd0);
      chk("t6b_addr", imem_addr, 32'h80);

      // Reset while a fetch is outstanding; late rvalid in IDLE is ignored
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; rst = 1'b0;
      tick();
      chk("t7_pc", pc, 32'h0);
      chk("t7_count", fetch_count, 32'd0);
      chk("t7_insn", insn, 32'h0);
      chk("t7_req", 32'(imem_req), 32'd0);
      rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_EEEE;
      tick();
      imem_rvalid = 1'b0;
      chk("t7_valid", 32'(insn_valid), 32'd0);
      chk("t7_insn_late", insn, 32'h0);
      chk("t7_req_after", 32'(imem_req), 32'd1);
      chk("t7_addr", imem_addr, 32'h0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
